// File: rtl/nlfsr_tap_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nlfsr_tap_engine : SIZE-bit NLFSR with byte-coded tap selectors, AND-pair |
// | nonlinear feedback and a start/busy/done shift sequencer.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nlfsr_tap_engine #(
  parameter int SIZE        = 32,
  parameter int NUM_OF_TAPS = 15,
  parameter int AND_PAIRS   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic [NUM_OF_TAPS*8-1:0] co_buf,
  input  logic [SIZE-1:0]          seed,
  input  logic [CNT_W-1:0]         cycles,
  output logic                     busy,
  output logic                     done,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic [SIZE-1:0]          state_out
);

  localparam int c_PAD = 256 - SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [SIZE-1:0]          r_reg;
  logic [NUM_OF_TAPS*8-1:0] r_coef;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_bit_out;
  logic                     r_bit_valid;
  logic                     w_accept;
  logic                     w_shift;
  logic [255:0]             w_ext;
  logic [NUM_OF_TAPS-1:0]   w_tap;
  logic                     w_fb;

  // Padding with the MSB makes every 8-bit index land on reg[SIZE-1] once out of range.
  assign w_ext = {{c_PAD{r_reg[SIZE-1]}}, r_reg};

  always_comb begin
    w_tap = '0;
    w_fb  = 1'b0;
    for (int i = 0; i < NUM_OF_TAPS; i++) begin
      w_tap[i] = w_ext[r_coef[i*8 +: 8]];
    end
    for (int j = 0; j < AND_PAIRS; j++) begin
      w_fb = w_fb ^ (w_tap[2*j] & w_tap[2*j+1]);
    end
    for (int i = 2*AND_PAIRS; i < NUM_OF_TAPS; i++) begin
      w_fb = w_fb ^ w_tap[i];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = (cycles != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_reg       <= '0;
      r_coef      <= '0;
      r_cnt       <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_coef <= co_buf;
        r_reg  <= seed;
        r_cnt  <= cycles;
      end
      if (w_shift) begin
        r_bit_out <= r_reg[0];
        r_reg     <= {w_fb, r_reg[SIZE-1:1]};
        r_cnt     <= r_cnt - CNT_W'(1);
      end
      // The last shift lands in DONE, so valid stays up through the done cycle.
      r_bit_valid <= w_shift;
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign state_out = r_reg;

endmodule
`default_nettype wire

// File: doc/nlfsr_tap_engine.md
Name: nlfsr_tap_engine

Overview:
- Parametrised successor to the fixed 8-position tap selector. It holds its own SIZE-bit NLFSR and selects NUM_OF_TAPS taps anywhere in the register, using 8-bit coefficients.
- Feedback function: AND_PAIRS nonlinear pair terms, XORed with all remaining linear taps.
- A start/busy/done sequencer runs a requested number of shift cycles and streams one output bit per cycle. The block sits between the coefficient buffer and the keystream/bit consumer.

Parameters:
- SIZE, 32, NLFSR width in bits (2..255).
- NUM_OF_TAPS, 15, number of tap selectors; must be ≥ 2*AND_PAIRS.
- AND_PAIRS, 1, number of AND terms, formed from tap pairs (1,2), (3,4), ...
- CNT_W, 16, width of the cycle-count request.

Ports:
- clk  in  1  single clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- co_buf  in  NUM_OF_TAPS*8  coefficients; tap i (1-based) uses co_buf[i*8-1 -: 8] as a register bit index.
- seed  in  SIZE  initial NLFSR contents, latched on accepted start.
- cycles  in  CNT_W  number of shifts to run, latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on completion.
- bit_out  out  1  bit shifted out of reg[0].
- bit_valid  out  1  bit_out qualifier.
- state_out  out  SIZE  current NLFSR contents.

Behaviour:
- Reset (res=0, asynchronous):
  - FSM goes to IDLE.
  - NLFSR, coefficient latch and counter clear to 0.
  - busy, done, bit_out, bit_valid = 0; state_out = 0.
  - Reset asserted mid-RUN aborts the run immediately and produces no done pulse.
- Coefficient decode:
  - An index below SIZE selects reg[index]; index 0 is legal.
  - Any index ≥ SIZE selects reg[SIZE-1].
  - Decoding uses the coefficient latch captured at start. co_buf changes during a run have no effect.
- Feedback, computed combinationally from the current reg:
  - f = XOR over j=0..AND_PAIRS-1 of (T[2j+1] & T[2j+2]), XORed with all of T[2*AND_PAIRS+1..NUM_OF_TAPS].
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch co_buf, load reg←seed and cnt←cycles.
  - If cycles≠0, go to RUN; otherwise go to DONE.
  - Outputs bit_valid=0 and done=0.
- RUN, on every edge:
  - bit_out←reg[0] and bit_valid←1.
  - reg←{f, reg[SIZE-1:1]} (right shift, feedback into the MSB).
  - cnt←cnt-1.
  - When cnt is 1 before the decrement, go to DONE on that edge.
  - busy=1 throughout RUN.
- DONE:
  - done=1 for exactly one cycle; this cycle coincides with the final bit_valid cycle.
  - The following edge returns to IDLE and clears bit_valid.
- Latency:
  - start sampled at edge 0; busy high from edge 0.
  - The first bit_valid appears after edge 1.
  - Exactly `cycles` bit_valid cycles occur, back-to-back.
- start while in RUN or DONE is ignored and is not queued.
- cycles=0: done is high during the cycle after edge 0, no bit_valid occurs, and state_out=seed.
- state_out is always reg and holds its value in IDLE. It keeps its value after DONE.
- bit_out holds its last value when bit_valid=0.
- Counter arithmetic is unsigned CNT_W. The maximum request is 2^CNT_W-1 shifts, with no wrap.

Test Plan:
- Basic stream:
  - Stimulus: all coefficients 8'h00, seed=32'h0000_0005, cycles=4.
  - Required: bit_out sequence 1,0,1,0 on four consecutive bit_valid cycles; f=0 throughout, so final state_out=32'h0000_0000; done coincides with the 4th bit_valid; busy high for 4 cycles.
- Out-of-range index clamp:
  - Stimulus: taps 1..14 = 8'hFF, tap 15 = 8'h00, seed=32'h8000_0000, cycles=1.
  - Required: bit_out=0; f=r31^r0=1; state_out=32'hC000_0000; done=1 on the same cycle as the single bit_valid.
- Zero-length request:
  - Stimulus: cycles=0, seed=32'hDEAD_BEEF.
  - Required: done pulses in the cycle after start; bit_valid stays 0; state_out=32'hDEAD_BEEF; FSM back in IDLE next edge.
- Start while busy:
  - Stimulus: cycles=8, with start re-pulsed at shift 3 and again during the DONE cycle.
  - Required: exactly 8 bit_valid cycles and a single done; a start in IDLE afterwards is accepted.
- Asynchronous reset mid-run:
  - Stimulus: res driven low between edges at shift 5 of 10.
  - Required: busy, bit_valid, done and state_out go to 0 without waiting for a clock edge; no done pulse; the block is in IDLE after res rises.
- Coefficient freeze:
  - Stimulus: change co_buf during RUN.
  - Required: output sequence identical to the run with co_buf held constant.
